// File: rtl/npu_axi_arbiter.sv
// Round-robin arbiter sharing the NPU AXI4 master port between NUM_CLIENTS requesters.
// Write (AW/W/B) and read (AR/R) sides arbitrate independently; NPU_AXI_ARB_PERF_EN adds per-client burst counters.
module npu_axi_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CLIENTS-1:0]          s_awvalid,
    output logic [NUM_CLIENTS-1:0]          s_awready,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   s_awaddr,
    input  logic [NUM_CLIENTS*8-1:0]        s_awlen,
    input  logic [NUM_CLIENTS*3-1:0]        s_awsize,
    input  logic [NUM_CLIENTS-1:0]          s_wvalid,
    output logic [NUM_CLIENTS-1:0]          s_wready,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   s_wdata,
    input  logic [NUM_CLIENTS*DATA_W/8-1:0] s_wstrb,
    input  logic [NUM_CLIENTS-1:0]          s_wlast,
    output logic [NUM_CLIENTS-1:0]          s_bvalid,
    input  logic [NUM_CLIENTS-1:0]          s_bready,
    input  logic [NUM_CLIENTS-1:0]          s_arvalid,
    output logic [NUM_CLIENTS-1:0]          s_arready,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   s_araddr,
    input  logic [NUM_CLIENTS*8-1:0]        s_arlen,
    input  logic [NUM_CLIENTS*3-1:0]        s_arsize,
    output logic [NUM_CLIENTS-1:0]          s_rvalid,
    input  logic [NUM_CLIENTS-1:0]          s_rready,
    output logic [DATA_W-1:0]               s_rdata,
    output logic                            s_rlast,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [ADDR_W-1:0]               m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [DATA_W-1:0]               m_axi_wdata,
    output logic [DATA_W/8-1:0]             m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    output logic [ADDR_W-1:0]               m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic [DATA_W-1:0]               m_axi_rdata,
    input  logic                            m_axi_rlast,
    output logic [NUM_CLIENTS-1:0]          wr_grant,
    output logic [NUM_CLIENTS-1:0]          rd_grant,
    output logic [NUM_CLIENTS*32-1:0]       perf_wr_bursts,
    output logic [NUM_CLIENTS*32-1:0]       perf_rd_bursts
);
    localparam int IDX_W  = $clog2(NUM_CLIENTS);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;

    logic [1:0]       w_state, r_state;
    logic [IDX_W-1:0] wr_idx, rd_idx, wr_ptr, rd_ptr;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // First requester at or after ptr, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               c;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_CLIENTS) c = c - NUM_CLIENTS;
            if (!found && req[c]) begin
                pick  = IDX_W'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid  & m_axi_rready;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            wr_idx  <= '0;
            wr_ptr  <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (|s_awvalid) begin
                    wr_idx  <= rr_pick(s_awvalid, wr_ptr);
                    w_state <= W_ADDR;
                end
                W_ADDR: if (aw_hs) w_state <= W_DATA;
                W_DATA: if (w_hs && m_axi_wlast) w_state <= W_RESP;
                W_RESP: if (b_hs) begin
                    wr_ptr  <= next_idx(wr_idx);
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rd_idx  <= '0;
            rd_ptr  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (|s_arvalid) begin
                    rd_idx  <= rr_pick(s_arvalid, rd_ptr);
                    r_state <= R_ADDR;
                end
                R_ADDR: if (ar_hs) r_state <= R_DATA;
                R_DATA: if (r_hs && m_axi_rlast) begin
                    rd_ptr  <= next_idx(rd_idx);
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output is defaulted first, so no branch leaves one unassigned (no latches, zeros when idle).
        wr_grant      = '0;
        s_awready     = '0;
        s_wready      = '0;
        s_bvalid      = '0;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_awsize  = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        if (w_state != W_IDLE) wr_grant[wr_idx] = 1'b1;
        case (w_state)
            W_ADDR: begin
                m_axi_awvalid     = s_awvalid[wr_idx];
                m_axi_awaddr      = s_awaddr[int'(wr_idx)*ADDR_W +: ADDR_W];
                m_axi_awlen       = s_awlen[int'(wr_idx)*8 +: 8];
                m_axi_awsize      = s_awsize[int'(wr_idx)*3 +: 3];
                s_awready[wr_idx] = m_axi_awready;
            end
            W_DATA: begin
                m_axi_wvalid     = s_wvalid[wr_idx];
                m_axi_wdata      = s_wdata[int'(wr_idx)*DATA_W +: DATA_W];
                m_axi_wstrb      = s_wstrb[int'(wr_idx)*STRB_W +: STRB_W];
                m_axi_wlast      = s_wlast[wr_idx];
                s_wready[wr_idx] = m_axi_wready;
            end
            W_RESP: begin
                s_bvalid[wr_idx] = m_axi_bvalid;
                m_axi_bready     = s_bready[wr_idx];
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_grant      = '0;
        s_arready     = '0;
        s_rvalid      = '0;
        s_rdata       = '0;
        s_rlast       = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arsize  = '0;
        m_axi_rready  = 1'b0;
        if (r_state != R_IDLE) rd_grant[rd_idx] = 1'b1;
        case (r_state)
            R_ADDR: begin
                m_axi_arvalid     = s_arvalid[rd_idx];
                m_axi_araddr      = s_araddr[int'(rd_idx)*ADDR_W +: ADDR_W];
                m_axi_arlen       = s_arlen[int'(rd_idx)*8 +: 8];
                m_axi_arsize      = s_arsize[int'(rd_idx)*3 +: 3];
                s_arready[rd_idx] = m_axi_arready;
            end
            R_DATA: begin
                s_rvalid[rd_idx] = m_axi_rvalid;
                s_rdata          = m_axi_rdata;
                s_rlast          = m_axi_rlast;
                m_axi_rready     = s_rready[rd_idx];
            end
            default: ;
        endcase
    end

`ifdef NPU_AXI_ARB_PERF_EN
    logic [31:0] wr_cnt [NUM_CLIENTS];
    logic [31:0] rd_cnt [NUM_CLIENTS];

    // Bursts count only on their completing handshake, so an abandoned burst never counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
            end
        end else begin
            if (w_state == W_RESP && b_hs) wr_cnt[wr_idx] <= wr_cnt[wr_idx] + 32'd1;
            if (r_state == R_DATA && r_hs && m_axi_rlast) rd_cnt[rd_idx] <= rd_cnt[rd_idx] + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            perf_wr_bursts[i*32 +: 32] = wr_cnt[i];
            perf_rd_bursts[i*32 +: 32] = rd_cnt[i];
        end
    end
`else
    assign perf_wr_bursts = '0;
    assign perf_rd_bursts = '0;
`endif

endmodule

// File: tb/tb_npu_axi_arbiter.sv
// Directed bench for npu_axi_arbiter: client tasks on the s_* side, a memory-backed AXI slave on m_axi_*.
module tb_npu_axi_arbiter;
    localparam int NC  = 2;
    localparam int AW  = 64;
    localparam int DW  = 256;
    localparam int SW  = DW / 8;
    localparam int TMO = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Per-client drive, packed onto the DUT vectors below.
    logic          cw_awvalid [NC];
    logic [AW-1:0] cw_awaddr  [NC];
    logic [7:0]    cw_awlen   [NC];
    logic          cw_wvalid  [NC];
    logic [DW-1:0] cw_wdata   [NC];
    logic          cw_wlast   [NC];
    logic          cw_bready  [NC];
    logic          cw_arvalid [NC];
    logic [AW-1:0] cw_araddr  [NC];
    logic [7:0]    cw_arlen   [NC];
    logic          cw_rready  [NC];

    logic [NC-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [NC-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NC*AW-1:0] s_awaddr, s_araddr;
    logic [NC*8-1:0]  s_awlen, s_arlen;
    logic [NC*3-1:0]  s_awsize, s_arsize;
    logic [NC*DW-1:0] s_wdata;
    logic [NC*SW-1:0] s_wstrb;
    logic [DW-1:0]    s_rdata;
    logic             s_rlast;

    logic          m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_awready = 1'b1;
    logic          m_axi_wready  = 1'b1;
    logic          m_axi_bvalid  = 1'b0;
    logic          m_axi_arready = 1'b1;
    logic          m_axi_rvalid  = 1'b0;
    logic [DW-1:0] m_axi_rdata   = '0;
    logic          m_axi_rlast   = 1'b0;
    logic [NC-1:0]    wr_grant, rd_grant;
    logic [NC*32-1:0] perf_wr_bursts, perf_rd_bursts;

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            s_awvalid[i]         = cw_awvalid[i];
            s_awaddr[i*AW +: AW] = cw_awaddr[i];
            s_awlen[i*8 +: 8]    = cw_awlen[i];
            s_awsize[i*3 +: 3]   = 3'd5;
            s_wvalid[i]          = cw_wvalid[i];
            s_wdata[i*DW +: DW]  = cw_wdata[i];
            s_wstrb[i*SW +: SW]  = '1;
            s_wlast[i]           = cw_wlast[i];
            s_bready[i]          = cw_bready[i];
            s_arvalid[i]         = cw_arvalid[i];
            s_araddr[i*AW +: AW] = cw_araddr[i];
            s_arlen[i*8 +: 8]    = cw_arlen[i];
            s_arsize[i*3 +: 3]   = 3'd5;
            s_rready[i]          = cw_rready[i];
        end
    end

    npu_axi_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rlast(s_rlast),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .wr_grant(wr_grant), .rd_grant(rd_grant),
        .perf_wr_bursts(perf_wr_bursts), .perf_rd_bursts(perf_rd_bursts)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int b);
        logic [DW-1:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = a[31:0] + 32'(b) * 32'h10 + 32'(j) + 32'hC0DE_0000;
        return v;
    endfunction

    function automatic logic [DW-1:0] init_pat(input int i);
        logic [DW-1:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = 32'h5A00_0000 + 32'(i) * 32'h100 + 32'(j * 17);
        return v;
    endfunction

    // Slave memory, one 256-bit word per key (byte address >> 5).
    logic [DW-1:0] mem [longint];
    function automatic logic [DW-1:0] mem_rd(input longint k);
        return mem.exists(k) ? mem[k] : '0;
    endfunction

    typedef struct {
        int            client;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_rec_t;
    aw_rec_t aw_log [$];

    int     b_cnt [NC];
    int     rl_cnt [NC];
    int     xtalk = 0;
    int     beat_err = 0;
    bit     wtoggle = 1'b0;
    logic   sm_rst, sm_aw, sm_w, sm_b, sm_ar, sm_r, sm_wlast;
    logic [AW-1:0] sm_awaddr, sm_araddr;
    logic [7:0]    sm_awlen, sm_arlen;
    logic [DW-1:0] sm_wdata;
    logic [NC-1:0] sm_grant;
    longint s_wbase, s_rcur;
    int     s_wbeat = 0, s_wlen = 0, s_rleft = 0;

    // Slave + monitor: sample at the edge, update its outputs 1 time unit later.
    always begin
        @(posedge clk);
        sm_rst = rst_n;
        sm_aw = m_axi_awvalid & m_axi_awready; sm_awaddr = m_axi_awaddr; sm_awlen = m_axi_awlen;
        sm_w = m_axi_wvalid & m_axi_wready;    sm_wdata = m_axi_wdata;   sm_wlast = m_axi_wlast;
        sm_b = m_axi_bvalid & m_axi_bready;
        sm_ar = m_axi_arvalid & m_axi_arready; sm_araddr = m_axi_araddr; sm_arlen = m_axi_arlen;
        sm_r = m_axi_rvalid & m_axi_rready;
        sm_grant = wr_grant;
        if (((s_awready | s_wready | s_bvalid) & ~wr_grant) != '0) xtalk++;
        if (((s_arready | s_rvalid) & ~rd_grant) != '0) xtalk++;
        for (int i = 0; i < NC; i++) begin
            if (s_bvalid[i] && s_bready[i]) b_cnt[i]++;
            if (s_rvalid[i] && s_rready[i] && s_rlast) rl_cnt[i]++;
        end
        #1;
        if (!sm_rst) begin
            m_axi_bvalid = 1'b0;
            m_axi_wready = 1'b1;
            s_wbeat = 0;
            s_rleft = 0;
        end else begin
            if (sm_aw) begin
                s_wbase = longint'(sm_awaddr >> 5);
                s_wlen  = int'(sm_awlen);
                s_wbeat = 0;
                aw_log.push_back('{sm_grant[1] ? 1 : 0, sm_awaddr, sm_awlen});
            end
            if (sm_w) begin
                mem[s_wbase + s_wbeat] = sm_wdata;
                if (sm_wlast != (s_wbeat == s_wlen)) beat_err++;
                if (sm_wlast) begin
                    m_axi_bvalid = 1'b1;
                    s_wbeat = 0;
                end else s_wbeat++;
            end
            if (sm_b) m_axi_bvalid = 1'b0;
            m_axi_wready = wtoggle ? ~m_axi_wready : 1'b1;
            if (sm_ar) begin
                s_rcur  = longint'(sm_araddr >> 5);
                s_rleft = int'(sm_arlen) + 1;
            end
            if (sm_r) begin
                s_rcur++;
                s_rleft--;
            end
        end
        m_axi_rvalid = (s_rleft > 0);
        m_axi_rdata  = (s_rleft > 0) ? mem_rd(s_rcur) : '0;
        m_axi_rlast  = (s_rleft == 1);
    end

    logic [DW-1:0] rbuf [NC][128];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input int c, input logic [AW-1:0] a, input logic [7:0] len, output int waits);
        bit hs = 1'b0;
        cw_awvalid[c] = 1'b1; cw_awaddr[c] = a; cw_awlen[c] = len;
        waits = 0;
        while (!hs && waits < TMO) begin
            @(negedge clk); hs = s_awready[c];
            cyc(); waits++;
        end
        cw_awvalid[c] = 1'b0;
        if (!hs) check("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input int c, input logic [DW-1:0] d, input bit last);
        bit hs = 1'b0;
        int n = 0;
        cw_wvalid[c] = 1'b1; cw_wdata[c] = d; cw_wlast[c] = last;
        while (!hs && n < TMO) begin
            @(negedge clk); hs = s_wready[c];
            cyc(); n++;
        end
        cw_wvalid[c] = 1'b0; cw_wlast[c] = 1'b0;
        if (!hs) check("w_timeout", 0, 1);
    endtask

    task automatic recv_b(input int c);
        bit hs = 1'b0;
        int n = 0;
        cw_bready[c] = 1'b1;
        while (!hs && n < TMO) begin
            @(negedge clk); hs = s_bvalid[c];
            cyc(); n++;
        end
        cw_bready[c] = 1'b0;
        if (!hs) check("b_timeout", 0, 1);
    endtask

    task automatic client_write(input int c, input logic [AW-1:0] a, input int len,
                                input bit from_buf, input int boff);
        int w;
        send_aw(c, a, 8'(len), w);
        for (int b = 0; b <= len; b++) send_w(c, from_buf ? rbuf[1][boff + b] : pat(a, b), b == len);
        recv_b(c);
    endtask

    task automatic client_read(input int c, input logic [AW-1:0] a, input int len,
                               input int stall, input int boff);
        bit hs = 1'b0;
        bit last = 1'b0;
        int n = 0;
        int beat = 0;
        cw_arvalid[c] = 1'b1; cw_araddr[c] = a; cw_arlen[c] = 8'(len);
        while (!hs && n < TMO) begin
            @(negedge clk); hs = s_arready[c];
            cyc(); n++;
        end
        cw_arvalid[c] = 1'b0;
        n = 0;
        while (!last && n < TMO) begin
            cw_rready[c] = (n >= stall);
            @(negedge clk);
            if (s_rvalid[c] && cw_rready[c]) begin
                rbuf[c][boff + beat] = s_rdata;
                last = s_rlast;
                beat++;
            end
            cyc(); n++;
        end
        cw_rready[c] = 1'b0;
        check("rd_beats", beat, len + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, errs, b0, b1, r0, r1, x0;
        logic [7:0] order;
        for (int i = 0; i < NC; i++) begin
            cw_awvalid[i] = 0; cw_awaddr[i] = '0; cw_awlen[i] = '0; cw_wvalid[i] = 0;
            cw_wdata[i] = '0; cw_wlast[i] = 0; cw_bready[i] = 0; cw_arvalid[i] = 0;
            cw_araddr[i] = '0; cw_arlen[i] = '0; cw_rready[i] = 0; b_cnt[i] = 0; rl_cnt[i] = 0;
        end
        for (int i = 0; i < 256; i++) mem[i] = init_pat(i);
        repeat (3) cyc();

        // Reset state, sampled while rst_n is still low.
        @(negedge clk);
        check("rst_grants", {wr_grant, rd_grant}, 0);
        check("rst_m_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check("rst_s_hs", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
        check("rst_payload", m_axi_awaddr | m_axi_araddr | m_axi_wdata | s_rdata, 0);
        check("rst_perf", {perf_wr_bursts, perf_rd_bursts}, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single write burst from client 0.
        b0 = b_cnt[0];
        aw_log.delete();
        send_aw(0, 64'h10_0000, 8'd7, w);
        // A one-cycle grant delay puts the AW handshake at the second sample.
        check("aw_latency", w, 2);
        for (int b = 0; b < 8; b++) send_w(0, pat(64'h10_0000, b), b == 7);
        recv_b(0);
        repeat (3) cyc();
        @(negedge clk);
        check("single_grant_idle", wr_grant, 0);
        check("single_b_once", b_cnt[0] - b0, 1);
        check("single_aw_count", aw_log.size(), 1);
        if (aw_log.size() > 0) begin
            check("single_aw_addr", aw_log[0].addr, 64'h10_0000);
            check("single_aw_len", aw_log[0].len, 7);
        end
        errs = 0;
        for (int b = 0; b < 8; b++) if (mem_rd((64'h10_0000 >> 5) + b) !== pat(64'h10_0000, b)) errs++;
        check("single_data", errs, 0);
        cyc();

        // Contention: both clients keep requesting four bursts each.
        do_reset();
        aw_log.delete();
        b0 = b_cnt[0]; b1 = b_cnt[1]; x0 = xtalk;
        fork
            for (int k = 0; k < 4; k++) client_write(0, 64'h2_0000 + 64'(k) * 64'h100, 1, 1'b0, 0);
            for (int k = 0; k < 4; k++) client_write(1, 64'h3_0000 + 64'(k) * 64'h100, 1, 1'b0, 0);
        join
        check("cont_aw_count", aw_log.size(), 8);
        order = '0;
        for (int k = 0; k < 8 && k < aw_log.size(); k++) order[k] = (aw_log[k].client == 1);
        check("cont_order", order, 8'hAA);
        check("cont_b", {b_cnt[0] - b0, b_cnt[1] - b1}, {32'd4, 32'd4});
        check("cont_xtalk", xtalk - x0, 0);

        // Concurrent read (client 0) and write (client 1).
        b0 = b_cnt[0]; b1 = b_cnt[1]; r0 = rl_cnt[0]; r1 = rl_cnt[1]; x0 = xtalk;
        fork
            client_read(0, 64'h1000, 3, 0, 0);
            client_write(1, 64'h3000, 3, 1'b0, 0);
        join
        errs = 0;
        for (int b = 0; b < 4; b++) if (rbuf[0][b] !== init_pat(128 + b)) errs++;
        check("conc_rdata", errs, 0);
        errs = 0;
        for (int b = 0; b < 4; b++) if (mem_rd((64'h3000 >> 5) + b) !== pat(64'h3000, b)) errs++;
        check("conc_wdata", errs, 0);
        check("conc_counts", {b_cnt[0] - b0, b_cnt[1] - b1, rl_cnt[0] - r0, rl_cnt[1] - r1},
              {32'd0, 32'd1, 32'd1, 32'd0});
        check("conc_xtalk", xtalk - x0, 0);

        // 4 KB copy 0x0 -> 0x10_0000 under W and R backpressure.
        wtoggle = 1'b1;
        for (int k = 0; k < 4; k++) client_read(1, 64'(k) * 64'h400, 31, 5, k * 32);
        for (int k = 0; k < 4; k++) client_write(0, 64'h10_0000 + 64'(k) * 64'h400, 31, 1'b1, k * 32);
        wtoggle = 1'b0;
        errs = 0;
        for (int i = 0; i < 128; i++) if (mem_rd((64'h10_0000 >> 5) + i) !== init_pat(i)) errs++;
        check("copy_bytes", errs, 0);
        check("copy_last_word", mem_rd((64'h10_0000 >> 5) + 127), init_pat(127));
        check("wlast_framing", beat_err, 0);

        // Reset on beat 3 of an 8-beat write, with wr_ptr pointing at client 1 beforehand.
        do_reset();
        client_write(0, 64'h4_0000, 0, 1'b0, 0);
        b1 = b_cnt[1];
        send_aw(1, 64'h5_0000, 8'd7, w);
        for (int b = 0; b < 3; b++) send_w(1, pat(64'h5_0000, b), 1'b0);
        cw_wvalid[1] = 1'b1; cw_wdata[1] = pat(64'h5_0000, 3);
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        check("midrst_grants", {wr_grant, rd_grant}, 0);
        check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                                s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
        cw_wvalid[1] = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("midrst_no_b", b_cnt[1] - b1, 0);
        aw_log.delete();
        fork
            client_write(0, 64'h6_0000, 0, 1'b0, 0);
            client_write(1, 64'h7_0000, 0, 1'b0, 0);
        join
        check("midrst_aw_count", aw_log.size(), 2);
        if (aw_log.size() > 0) check("midrst_first_client", aw_log[0].client, 0);

        // Burst counters: 3 writes by client 0, 2 reads by client 1.
        do_reset();
        for (int k = 0; k < 3; k++) client_write(0, 64'h8_0000 + 64'(k) * 64'h100, 1, 1'b0, 0);
        for (int k = 0; k < 2; k++) client_read(1, 64'h0, 1, 0, 0);
        cyc();
        @(negedge clk);
`ifdef NPU_AXI_ARB_PERF_EN
        check("perf_wr", perf_wr_bursts, {32'd0, 32'd3});
        check("perf_rd", perf_rd_bursts, {32'd2, 32'd0});
`else
        check("perf_wr", perf_wr_bursts, 0);
        check("perf_rd", perf_rd_bursts, 0);
`endif
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
